// File: rtl/smi_phy_seq.sv
// smi_phy_seq: PHY power-up, BMCR soft reset/config and periodic BMSR poll.
// Define SMI_SEQ_DOUBLE_READ_EN to read BMSR twice per poll.
module smi_phy_seq #(
  parameter logic [4:0]  PHY_ADR        = 5'd0,
  parameter logic [15:0] BMCR_CFG       = 16'h1000,
  parameter logic [19:0] PWRUP_CYCLES   = 20'd500000,
  parameter logic [23:0] POLL_CYCLES    = 24'd2000000,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024,
  parameter logic [3:0]  RST_POLL_MAX   = 4'd8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        smi_trg_o,
  output logic        smi_rw_o,
  output logic [4:0]  smi_phy_adr_o,
  output logic [4:0]  smi_reg_adr_o,
  output logic [15:0] smi_wdata_o,
  input  logic        smi_ready_i,
  input  logic        smi_ack_i,
  input  logic [15:0] smi_rdata_i,
  output logic        cfg_done_o,
  output logic        link_up_o,
  output logic [15:0] bmsr_o,
  output logic        fault_o
);

`ifdef SMI_SEQ_DOUBLE_READ_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_PWRUP, S_RST_WR, S_RST_RD, S_CFG_WR,
    S_POLL_WAIT, S_STAT_RD, S_FAULT
  } st_e;

  typedef enum logic [1:0] {
    T_IDLE, T_ARM, T_WAIT
  } tst_e;

  st_e         st_q, st_d;
  tst_e        tst_q, tst_d;
  logic [23:0] cnt_q, cnt_d;
  logic [15:0] tmo_q, tmo_d;
  logic [3:0]  rpl_q, rpl_d;
  logic        dbl_q, dbl_d;
  logic        trg_q, trg_d;
  logic        rw_q, rw_d;
  logic [4:0]  reg_q, reg_d;
  logic [15:0] wd_q, wd_d;
  logic        cfg_q, cfg_d;
  logic        link_q, link_d;
  logic [15:0] bmsr_q, bmsr_d;
  logic        flt_q, flt_d;

  logic txn_st, done, tmo_hit, tmo_flt;
  logic pw_end, poll_end, rd_ok, rpl_last, rd_again;

  assign txn_st = (st_q == S_RST_WR) || (st_q == S_RST_RD)
               || (st_q == S_CFG_WR) || (st_q == S_STAT_RD);
  assign done = (tst_q == T_WAIT) && smi_ready_i;
  assign tmo_hit = (tst_q != T_IDLE)
    && (({1'b0, tmo_q} + 17'd1) >= {1'b0, TIMEOUT_CYCLES});
  assign tmo_flt = tmo_hit && !done;
  assign pw_end = ({1'b0, cnt_q} + 25'd1) >= {5'd0, PWRUP_CYCLES};
  assign poll_end = ({1'b0, cnt_q} + 25'd1) >= {1'b0, POLL_CYCLES};
  assign rd_ok = smi_ack_i && !smi_rdata_i[15];
  assign rpl_last = ({1'b0, rpl_q} + 5'd1) >= {1'b0, RST_POLL_MAX};
  // first acked BMSR read only clears the latched-low bit
  assign rd_again = DBL && !dbl_q && smi_ack_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= S_PWRUP;
      tst_q  <= T_IDLE;
      cnt_q  <= '0;
      tmo_q  <= '0;
      rpl_q  <= '0;
      dbl_q  <= 1'b0;
      trg_q  <= 1'b0;
      rw_q   <= 1'b0;
      reg_q  <= '0;
      wd_q   <= '0;
      cfg_q  <= 1'b0;
      link_q <= 1'b0;
      bmsr_q <= '0;
      flt_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      tst_q  <= tst_d;
      cnt_q  <= cnt_d;
      tmo_q  <= tmo_d;
      rpl_q  <= rpl_d;
      dbl_q  <= dbl_d;
      trg_q  <= trg_d;
      rw_q   <= rw_d;
      reg_q  <= reg_d;
      wd_q   <= wd_d;
      cfg_q  <= cfg_d;
      link_q <= link_d;
      bmsr_q <= bmsr_d;
      flt_q  <= flt_d;
    end
  end

  always_comb begin
    tst_d = tst_q;
    unique case (tst_q)
      T_IDLE: if (txn_st) tst_d = T_ARM;
      T_ARM: begin
        if (tmo_hit) tst_d = T_IDLE;
        else if (!smi_ready_i) tst_d = T_WAIT;
      end
      T_WAIT: if (done || tmo_hit) tst_d = T_IDLE;
      default: tst_d = T_IDLE;
    endcase

    st_d = st_q;
    if (tmo_flt) begin
      st_d = S_FAULT;
    end else begin
      unique case (st_q)
        S_PWRUP:     if (pw_end) st_d = S_RST_WR;
        S_RST_WR:    if (done) st_d = S_RST_RD;
        S_RST_RD: begin
          if (done && rd_ok) st_d = S_CFG_WR;
          else if (done && rpl_last) st_d = S_FAULT;
        end
        S_CFG_WR:    if (done) st_d = S_POLL_WAIT;
        S_POLL_WAIT: if (poll_end) st_d = S_STAT_RD;
        S_STAT_RD:   if (done && !rd_again) st_d = S_POLL_WAIT;
        S_FAULT:     st_d = S_FAULT;
        default:     st_d = S_FAULT;
      endcase
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    tmo_d  = tmo_q;
    rpl_d  = rpl_q;
    dbl_d  = dbl_q;
    trg_d  = trg_q;
    rw_d   = rw_q;
    reg_d  = reg_q;
    wd_d   = wd_q;
    cfg_d  = cfg_q;
    link_d = link_q;
    bmsr_d = bmsr_q;
    flt_d  = flt_q;

    if (st_d != st_q) begin
      cnt_d = '0;
    end else if ((st_q == S_PWRUP || st_q == S_POLL_WAIT)
                 && cnt_q != '1) begin
      cnt_d = cnt_q + 24'd1;
    end

    if (tst_q == T_IDLE && txn_st) begin
      trg_d = 1'b1;
      tmo_d = '0;
      rw_d  = (st_q == S_RST_WR) || (st_q == S_CFG_WR);
      reg_d = (st_q == S_STAT_RD) ? 5'd1 : 5'd0;
      wd_d  = (st_q == S_RST_WR) ? 16'h8000 :
              (st_q == S_CFG_WR) ? BMCR_CFG : 16'h0000;
    end

    if (tst_q != T_IDLE && tmo_q != '1) tmo_d = tmo_q + 16'd1;
    if (done || tmo_hit) trg_d = 1'b0;

    if (tmo_flt) begin
      flt_d  = 1'b1;
      link_d = 1'b0;
    end

    if (done) begin
      unique case (1'b1)
        st_q == S_RST_RD: begin
          if (rd_ok) begin
            rpl_d = '0;
          end else begin
            if (rpl_q != '1) rpl_d = rpl_q + 4'd1;
            if (rpl_last) begin
              flt_d  = 1'b1;
              link_d = 1'b0;
            end
          end
        end
        st_q == S_CFG_WR: cfg_d = 1'b1;
        st_q == S_STAT_RD: begin
          if (rd_again) begin
            dbl_d = 1'b1;
          end else begin
            dbl_d = 1'b0;
            if (smi_ack_i) begin
              bmsr_d = smi_rdata_i;
              link_d = smi_rdata_i[2];
            end else begin
              link_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign smi_trg_o     = trg_q;
  assign smi_rw_o      = rw_q;
  assign smi_phy_adr_o = PHY_ADR;
  assign smi_reg_adr_o = reg_q;
  assign smi_wdata_o   = wd_q;
  assign cfg_done_o    = cfg_q;
  assign link_up_o     = link_q;
  assign bmsr_o        = bmsr_q;
  assign fault_o       = flt_q;

endmodule

// File: tb/tb_smi_phy_seq.sv
// tb_smi_phy_seq: directed bench for smi_phy_seq with an SMI engine model
// and a transaction-level reference model compared every cycle.
module tb_smi_phy_seq;

  localparam int PW  = 10;
  localparam int PL  = 100;
  localparam int TO  = 200;
  localparam int RPM = 3;
  localparam int LAT = 70;

`ifdef SMI_SEQ_DOUBLE_READ_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        smi_trg_o, smi_rw_o;
  logic [4:0]  smi_phy_adr_o, smi_reg_adr_o;
  logic [15:0] smi_wdata_o;
  logic        smi_ready_i = 1'b1;
  logic        smi_ack_i = 1'b0;
  logic [15:0] smi_rdata_i = 16'h0000;
  logic        cfg_done_o, link_up_o, fault_o;
  logic [15:0] bmsr_o;

  always #5 clk = ~clk;

  smi_phy_seq #(
    .PHY_ADR(5'd0),
    .BMCR_CFG(16'h1000),
    .PWRUP_CYCLES(20'd10),
    .POLL_CYCLES(24'd100),
    .TIMEOUT_CYCLES(16'd200),
    .RST_POLL_MAX(4'd3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .smi_trg_o(smi_trg_o),
    .smi_rw_o(smi_rw_o),
    .smi_phy_adr_o(smi_phy_adr_o),
    .smi_reg_adr_o(smi_reg_adr_o),
    .smi_wdata_o(smi_wdata_o),
    .smi_ready_i(smi_ready_i),
    .smi_ack_i(smi_ack_i),
    .smi_rdata_i(smi_rdata_i),
    .cfg_done_o(cfg_done_o),
    .link_up_o(link_up_o),
    .bmsr_o(bmsr_o),
    .fault_o(fault_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // engine model: ready drops on trigger, rises LAT cycles after it
  logic        hang = 1'b0;
  logic        r0_ack = 1'b1;
  logic [15:0] r0_val = 16'h0000;
  logic [16:0] stat_q[$];
  logic [16:0] resp;
  bit          busy, e_prev, eng_done;
  int          ecnt, ntx, nr0;

  always @(negedge clk) begin
    if (!rst) begin
      busy = 0; e_prev = 0; ecnt = 0; ntx = 0; nr0 = 0;
    end else begin
      if (smi_trg_o && !e_prev) begin
        busy = 1; ecnt = 1; eng_done = 0;
        smi_ready_i = 1'b0;
        ntx++;
        if (!smi_rw_o && smi_reg_adr_o == 5'd0) nr0++;
      end else if (busy && smi_trg_o) begin
        ecnt++;
        if (ecnt >= LAT && !hang) begin
          busy = 0; eng_done = 1;
          if (smi_rw_o) begin
            smi_ack_i = 1'b0; smi_rdata_i = 16'h0000;
          end else if (smi_reg_adr_o == 5'd0) begin
            smi_ack_i = r0_ack; smi_rdata_i = r0_val;
          end else if (stat_q.size() > 0) begin
            resp = stat_q.pop_front();
            smi_ack_i = resp[16]; smi_rdata_i = resp[15:0];
          end else begin
            smi_ack_i = 1'b1; smi_rdata_i = 16'h0000;
          end
          smi_ready_i = 1'b1;
        end
      end else if (!smi_trg_o) begin
        busy = 0;
      end
      e_prev = smi_trg_o;
    end
  end

  // reference model: phase of the bring-up/poll sequence
  int          ph, rtries, lowcnt, n_done, n_poll;
  logic        exp_cfg, exp_link, exp_flt;
  logic [15:0] exp_bmsr;
  bit          prev_trg;
  logic        rw_c;
  logic [4:0]  reg_c;
  logic [15:0] wd_c;

  always @(negedge clk) begin
    if (!rst) begin
      ph = 0; rtries = 0; lowcnt = 0; n_done = 0; n_poll = 0;
      exp_cfg = 0; exp_link = 0; exp_flt = 0; exp_bmsr = 16'h0000;
      prev_trg = 0;
      chk("rst_trg", smi_trg_o, 0);
      chk("rst_rw", smi_rw_o, 0);
      chk("rst_reg", smi_reg_adr_o, 0);
      chk("rst_wdata", smi_wdata_o, 0);
    end else begin
      if (smi_trg_o && !prev_trg) begin
        if (exp_flt) begin
          chk("trg_after_fault", smi_trg_o, 0);
        end else begin
          chk("txn_rw", smi_rw_o, (ph == 0 || ph == 2));
          chk("txn_reg", smi_reg_adr_o, (ph >= 3) ? 1 : 0);
          if (ph == 0) chk("txn_wdata", smi_wdata_o, 16'h8000);
          if (ph == 2) chk("txn_wdata", smi_wdata_o, 16'h1000);
          chk("txn_gap", lowcnt,
              (ph == 0) ? PW + 1 : (ph == 3) ? PL + 1 : 1);
        end
        rw_c = smi_rw_o; reg_c = smi_reg_adr_o; wd_c = smi_wdata_o;
      end else if (smi_trg_o) begin
        chk("hold_rw", smi_rw_o, rw_c);
        chk("hold_reg", smi_reg_adr_o, reg_c);
        chk("hold_wdata", smi_wdata_o, wd_c);
      end
      if (!smi_trg_o && prev_trg && !exp_flt) begin
        lowcnt = 0;
        n_done++;
        if (!eng_done) begin
          exp_flt = 1; exp_link = 0;
        end else begin
          case (ph)
            0: begin ph = 1; rtries = 0; end
            1: begin
              if (smi_ack_i && !smi_rdata_i[15]) begin
                ph = 2;
              end else begin
                rtries++;
                if (rtries >= RPM) begin exp_flt = 1; exp_link = 0; end
              end
            end
            2: begin exp_cfg = 1; ph = 3; end
            default: begin
              if (DBL && ph == 3 && smi_ack_i) begin
                ph = 4;
              end else begin
                if (smi_ack_i) begin
                  exp_bmsr = smi_rdata_i; exp_link = smi_rdata_i[2];
                end else begin
                  exp_link = 0;
                end
                ph = 3;
                n_poll++;
              end
            end
          endcase
        end
      end
      if (!smi_trg_o) lowcnt++;
      if (exp_flt) chk("trg_in_fault", smi_trg_o, 0);
      prev_trg = smi_trg_o;
    end
    chk("fault_o", fault_o, exp_flt);
    chk("link_up_o", link_up_o, exp_link);
    chk("bmsr_o", bmsr_o, exp_bmsr);
    chk("cfg_done_o", cfg_done_o, exp_cfg);
    chk("phy_adr", smi_phy_adr_o, 0);
  end

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic wait_poll(input int n);
    bit found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk); #1;
      if (n_poll >= n) found = 1;
    end
    chk("wait_poll", found, 1);
  endtask

  task automatic wait_fault();
    bit found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk); #1;
      if (fault_o) found = 1;
    end
    chk("wait_fault", found, 1);
  endtask

  logic [16:0] exp_poll[4];

  initial begin
    int  n;
    bit  found;
`ifdef SMI_SEQ_DOUBLE_READ_EN
    exp_poll = '{17'h07809, 17'h07809, 17'h10024, 17'h00000};
`else
    exp_poll = '{17'h1782D, 17'h07809, 17'h07809, 17'h10004};
`endif

    // bring-up and polling
    stat_q = '{17'h1782D, 17'h17809, 17'h00000, 17'h10004, 17'h10024};
    do_reset();
    n = 0; found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk); #1;
      if (smi_trg_o) found = 1;
      else n++;
    end
    chk("pwrup_gap", n, PW + 1);

    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk); #1;
      if (ntx == 3 && smi_ready_i) found = 1;
    end
    chk("wait_rdy3", found, 1);
    chk("cfg_before", cfg_done_o, 0);
    @(negedge clk); #1;
    chk("cfg_after", cfg_done_o, 1);

    for (int p = 1; p <= 4; p++) begin
      wait_poll(p);
      chk("poll_link", link_up_o, exp_poll[p-1][16]);
      chk("poll_bmsr", bmsr_o, exp_poll[p-1][15:0]);
      if (p == 3) begin
        n = 0; found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
          @(negedge clk); #1;
          if (smi_trg_o) found = 1;
          else n++;
        end
        chk("poll_gap", n, PL);
      end
    end

    // async reset while a transaction is in flight
    found = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk); #1;
      if (smi_trg_o) found = 1;
    end
    chk("trg_before_rst", smi_trg_o, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_trg", smi_trg_o, 0);
    chk("mid_rst_rw", smi_rw_o, 0);
    chk("mid_rst_reg", smi_reg_adr_o, 0);
    chk("mid_rst_wdata", smi_wdata_o, 0);
    chk("mid_rst_cfg", cfg_done_o, 0);
    chk("mid_rst_link", link_up_o, 0);
    chk("mid_rst_bmsr", bmsr_o, 0);
    chk("mid_rst_fault", fault_o, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk); #1;
      if (n_done >= 1) found = 1;
    end
    chk("restart_txn", found, 1);

    // BMCR reset bit never clears
    r0_val = 16'h8000;
    do_reset();
    wait_fault();
    chk("rstpoll_fault", fault_o, 1);
    chk("rstpoll_reads", nr0, RPM);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (smi_trg_o) n++;
    end
    chk("trg_held_low", n, 0);

    // unacknowledged BMCR reads count as failed attempts
    r0_val = 16'h0000; r0_ack = 1'b0;
    do_reset();
    wait_fault();
    chk("noack_fault", fault_o, 1);
    chk("noack_reads", nr0, RPM);
    r0_ack = 1'b1;

    // engine never signals ready
    hang = 1'b1;
    do_reset();
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk); #1;
      if (smi_trg_o) found = 1;
    end
    chk("tmo_trg_rise", found, 1);
    n = 1;
    for (int i = 0; i < 400 && smi_trg_o; i++) begin
      @(negedge clk); #1;
      if (smi_trg_o) n++;
    end
    chk("tmo_high_cycles", n, TO);
    chk("tmo_trg_low", smi_trg_o, 0);
    chk("tmo_fault", fault_o, 1);
    hang = 1'b0;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
